// File: rtl/neuromorphic_x1_wb_ctrl.sv
// Wishbone-classic slave driving one NEUROMORPHIC_X1 macro: one bus transfer becomes one
// macro command, with a cycle-count timeout guarding against a macro that never completes.
module neuromorphic_x1_wb_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned CNT_W          = 10,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_0BAD
) (
   input  logic        CLKin,
   input  logic        RSTin,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        mac_EN,
   output logic        mac_R_WB,
   output logic [31:0] mac_AD,
   output logic [31:0] mac_DI,
   output logic [3:0]  mac_SEL,
   input  logic [31:0] mac_DO,
   input  logic        mac_func_ack,
   output logic        busy_o,
   output logic        timeout_o,
   output logic [7:0]  to_count_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] timer;

   always_ff @(posedge CLKin or posedge RSTin) begin
      if (RSTin) begin
         state      <= S_IDLE;
         timer      <= '0;
         wb_dat_o   <= '0;
         wb_ack_o   <= 1'b0;
         mac_EN     <= 1'b0;
         mac_R_WB   <= 1'b0;
         mac_AD     <= '0;
         mac_DI     <= '0;
         mac_SEL    <= '0;
         busy_o     <= 1'b0;
         timeout_o  <= 1'b0;
         to_count_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                  mac_AD   <= wb_adr_i;
                  mac_DI   <= wb_dat_i;
                  mac_SEL  <= wb_sel_i;
                  mac_R_WB <= ~wb_we_i;
                  mac_EN   <= 1'b1;
                  busy_o   <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mac_EN <= 1'b0;
               timer  <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // Completion is checked before expiry so an ack on the last cycle still wins.
               // The ack is only raised if the master still holds the cycle open.
               if (mac_func_ack) begin
                  wb_ack_o <= wb_cyc_i;
                  wb_dat_o <= (wb_cyc_i && mac_R_WB) ? mac_DO : '0;
                  state    <= S_RESP;
               end else if (timer == TIMER_LAST) begin
                  timeout_o <= 1'b1;
                  if (to_count_o != 8'hFF)
                     to_count_o <= to_count_o + 8'd1;
                  wb_ack_o <= wb_cyc_i;
                  wb_dat_o <= (wb_cyc_i && mac_R_WB) ? TIMEOUT_DATA : '0;
                  state    <= S_RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_RESP: begin
               wb_ack_o <= 1'b0;
               wb_dat_o <= '0;
               busy_o   <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuromorphic_x1_wb_ctrl.sv
// Randomized scoreboard bench for neuromorphic_x1_wb_ctrl: the driver predicts each
// macro command and bus acknowledge; monitors pop and compare when the DUT presents them.
module tb_neuromorphic_x1_wb_ctrl;

   localparam int unsigned TO  = 20;
   localparam int unsigned CW  = 5;
   localparam logic [31:0] TOD = 32'hDEAD_0BAD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0, dati = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        mac_EN, mac_R_WB;
   logic [31:0] mac_AD, mac_DI;
   logic [3:0]  mac_SEL;
   logic [31:0] mac_DO = '0;
   logic        func_ack = 1'b0;
   logic        busy_o, timeout_o;
   logic [7:0]  to_count_o;

   neuromorphic_x1_wb_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW), .TIMEOUT_DATA(TOD)) dut (
      .CLKin(clk), .RSTin(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(dati), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .mac_EN(mac_EN), .mac_R_WB(mac_R_WB), .mac_AD(mac_AD), .mac_DI(mac_DI),
      .mac_SEL(mac_SEL), .mac_DO(mac_DO), .mac_func_ack(func_ack),
      .busy_o(busy_o), .timeout_o(timeout_o), .to_count_o(to_count_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic [31:0] dat;
      int unsigned cyc;
      logic [7:0]  toc;
      logic        tof;
   } ack_t;

   typedef struct {
      logic        rwb;
      logic [31:0] ad;
      logic [31:0] di;
      logic [3:0]  sel;
      int unsigned cyc;
   } cmd_t;

   ack_t ackq[$];
   cmd_t cmdq[$];
   ack_t a_m;
   cmd_t c_m;

   int          checks = 0;
   int          errors = 0;
   int unsigned model_toc = 0;
   logic        model_tof = 1'b0;
   logic        prev_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h @cycle %0d", nm, act, exp, cyc_cnt);
      end
   endtask

   // Bus-side monitor: every acknowledge must match the oldest predicted response.
   always @(negedge clk) begin
      if (wb_ack_o) begin
         if (ackq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack actual=1 expected=0 @cycle %0d", cyc_cnt);
         end else begin
            a_m = ackq.pop_front();
            chk("ack_dat", wb_dat_o, a_m.dat);
            chk("ack_cycle", cyc_cnt, a_m.cyc);
            chk("ack_to_count", 32'(to_count_o), 32'(a_m.toc));
            chk("ack_timeout_flag", 32'(timeout_o), 32'(a_m.tof));
         end
      end
   end

   // Macro-side monitor: every enable pulse is one cycle wide and carries the predicted command.
   always @(negedge clk) begin
      if (mac_EN) begin
         if (prev_en) begin
            checks++;
            errors++;
            $display("FAIL en_width actual=2+ expected=1 @cycle %0d", cyc_cnt);
         end
         if (cmdq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_en actual=1 expected=0 @cycle %0d", cyc_cnt);
         end else begin
            c_m = cmdq.pop_front();
            chk("cmd_rwb", 32'(mac_R_WB), 32'(c_m.rwb));
            chk("cmd_ad", mac_AD, c_m.ad);
            chk("cmd_di", mac_DI, c_m.di);
            chk("cmd_sel", 32'(mac_SEL), 32'(c_m.sel));
            chk("cmd_cycle", cyc_cnt, c_m.cyc);
         end
      end
      prev_en = mac_EN;
   end

   // One transfer. d = cycles from enable to completion (d > TO means the macro never completes).
   // drop_k != 0 drops the bus cycle in that cycle after acceptance.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] dv,
                       input logic [3:0] s, input int unsigned d, input int unsigned drop_k,
                       input logic spur);
      int unsigned c0;
      int unsigned eff;
      int unsigned lat;
      logic        timed;
      logic [31:0] dout;
      ack_t        ae;
      cmd_t        ce;
      c0    = cyc_cnt;
      timed = (d > TO);
      eff   = timed ? TO : d;
      lat   = 2 + eff;
      dout  = $urandom;
      mac_DO = dout;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = dv; sel = s;
      ce.rwb = ~w; ce.ad = a; ce.di = dv; ce.sel = s; ce.cyc = c0 + 1;
      cmdq.push_back(ce);
      if (timed) begin
         model_tof = 1'b1;
         if (model_toc < 255) model_toc++;
      end
      if (drop_k == 0) begin
         ae.dat = w ? 32'h0 : (timed ? TOD : dout);
         ae.cyc = c0 + lat;
         ae.toc = 8'(model_toc);
         ae.tof = model_tof;
         ackq.push_back(ae);
      end
      for (int unsigned k = 1; k <= lat; k++) begin
         @(negedge clk);
         func_ack = (k == 1 + d) || (spur && (k == 1 || k == lat));
         if (drop_k != 0 && k == drop_k) begin
            cyc = 1'b0;
            stb = 1'b0;
         end
      end
      @(negedge clk);
      func_ack = 1'b0;
      chk("busy_after_xfer", 32'(busy_o), 32'h0);
      chk("dat_after_ack", wb_dat_o, 32'h0);
      chk("ack_pending", 32'(ackq.size()), 32'h0);
      ackq.delete();
   endtask

   task automatic idle(input int unsigned n, input logic pulse);
      cyc = 1'b0;
      stb = 1'b0;
      repeat (n) begin
         @(negedge clk);
         func_ack = pulse ? 1'($urandom % 2) : 1'b0;
      end
      @(negedge clk);
      func_ack = 1'b0;
      chk("idle_busy", 32'(busy_o), 32'h0);
      chk("idle_to_count", 32'(to_count_o), model_toc);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, 32'(wb_ack_o), 32'h0);
      chk({tag, "_dat"}, wb_dat_o, 32'h0);
      chk({tag, "_en"}, 32'(mac_EN), 32'h0);
      chk({tag, "_rwb"}, 32'(mac_R_WB), 32'h0);
      chk({tag, "_ad"}, mac_AD, 32'h0);
      chk({tag, "_di"}, mac_DI, 32'h0);
      chk({tag, "_sel"}, 32'(mac_SEL), 32'h0);
      chk({tag, "_busy"}, 32'(busy_o), 32'h0);
      chk({tag, "_timeout"}, 32'(timeout_o), 32'h0);
      chk({tag, "_to_count"}, 32'(to_count_o), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned d;
      int unsigned drop;
      logic        w;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Write acked two cycles after enable; read acked in the first WAIT cycle.
      xfer(1'b1, 32'h0000_0005, 32'hA5A5_5A5A, 4'hF, 2, 0, 1'b0);
      xfer(1'b0, 32'h0000_001F, 32'h0, 4'hF, 1, 0, 1'b0);
      // Read that never completes times out.
      xfer(1'b0, 32'h0000_0003, 32'h0, 4'h3, TO + 5, 0, 1'b0);
      chk("t3_timeout", 32'(timeout_o), 32'h1);
      chk("t3_to_count", 32'(to_count_o), 32'h1);
      // Master abandons during WAIT, then a normal read follows.
      xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, 5, 3, 1'b0);
      xfer(1'b0, 32'h0000_0011, 32'h0, 4'hF, 3, 0, 1'b0);
      // Completion on the very last WAIT cycle still succeeds.
      xfer(1'b0, 32'h0000_0012, 32'h0, 4'h1, TO, 0, 1'b1);
      idle(3, 1'b1);

      for (int i = 0; i < 60; i++) begin
         w    = 1'($urandom % 2);
         d    = 1 + ($urandom % (TO + 3));
         drop = ($urandom % 6 == 0) ? 1 + ($urandom % (1 + (d > TO ? TO : d))) : 0;
         xfer(w, $urandom, $urandom, 4'($urandom), d, drop, 1'($urandom % 2));
         if ($urandom % 4 == 0) idle(1 + $urandom % 3, 1'b1);
      end

      // Asynchronous reset in the middle of WAIT.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0007; sel = 4'hF;
      c_m.rwb = 1'b1; c_m.ad = adr; c_m.di = dati; c_m.sel = sel; c_m.cyc = cyc_cnt + 1;
      cmdq.push_back(c_m);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      cyc = 1'b0;
      stb = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_toc = 0;
      model_tof = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(TO + 5, 1'b0);
      chk_all_zero("postreset");
      xfer(1'b0, 32'h0000_0008, 32'h0, 4'hF, 4, 0, 1'b0);

      // Drive the timeout counter into saturation, with stray completions while idle.
      for (int i = 0; i < 256; i++) begin
         xfer(1'($urandom % 2), $urandom, $urandom, 4'($urandom), TO + 1 + $urandom % 3,
              0, 1'($urandom % 2));
         if (i % 32 == 0) idle(2, 1'b1);
      end
      chk("sat_to_count", 32'(to_count_o), 32'd255);
      xfer(1'b0, 32'h0000_0009, 32'h0, 4'hF, TO + 4, 0, 1'b0);
      chk("sat_hold", 32'(to_count_o), 32'd255);
      chk("sat_timeout", 32'(timeout_o), 32'h1);
      idle(4, 1'b1);

      chk("cmd_queue_empty", 32'(cmdq.size()), 32'h0);
      chk("ack_queue_empty", 32'(ackq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
